// File: rtl/unstrip_scheduler.sv
// Two-lane reassembly scheduler: per-lane FIFOs absorb inter-lane skew and a
// strict lane0/lane1 alternation rebuilds the original word order onto one output.
module unstrip_scheduler #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk_2f,
  input  logic                     reset_L,
  input  logic                     flush,
  input  logic                     valid_0,
  input  logic [DATA_W-1:0]        lane_0,
  input  logic                     valid_1,
  input  logic [DATA_W-1:0]        lane_1,
  input  logic                     ready_out,
  output logic [DATA_W-1:0]        data_out,
  output logic                     valid_out,
  output logic                     exp_lane,
  output logic                     active,
  output logic                     overflow_err,
  output logic [$clog2(DEPTH):0]   fill_0,
  output logic [$clog2(DEPTH):0]   fill_1
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {
    EXP0 = 1'b0,
    EXP1 = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0]     data_q, data_d;
  logic                  valid_out_q, valid_out_d;
  logic                  active_q, active_d;
  logic                  ovf_q, ovf_d;

  logic [1:0][AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [1:0][AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [1:0][AW:0]      cnt_q, cnt_d;

  logic [DATA_W-1:0]     mem [2][DEPTH];

  logic [1:0][DATA_W-1:0] din;
  logic [1:0]             vld_in;
  logic [1:0]             full;
  logic [1:0]             pop;
  logic [1:0]             push;
  logic [1:0]             wr_en;
  logic                   slot_free;
  logic                   lane_sel;
  logic                   drop;
  logic [DATA_W-1:0]      head;

  assign din    = {lane_1, lane_0};
  assign vld_in = {valid_1, valid_0};

  // Pop/push decisions; a full FIFO still accepts a word when its head leaves on the same edge.
  always_comb begin
    slot_free = !valid_out_q || ready_out;
    lane_sel  = (state_q == EXP1);
    pop       = '0;
    push      = '0;
    full      = '0;
    if ((cnt_q[lane_sel] != '0) && slot_free) begin
      pop[lane_sel] = 1'b1;
    end
    for (int i = 0; i < 2; i++) begin
      full[i] = (cnt_q[i] == (AW+1)'(DEPTH));
      push[i] = vld_in[i] && (!full[i] || pop[i]);
    end
    drop  = |(vld_in & ~push);
    wr_en = push & {2{!flush}};
    head  = mem[lane_sel][rd_ptr_q[lane_sel]];
  end

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    valid_out_d = valid_out_q;
    active_d    = active_q;
    ovf_d       = ovf_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    if (flush) begin
      state_d     = EXP0;
      data_d      = '0;
      valid_out_d = 1'b0;
      active_d    = 1'b0;
      ovf_d       = 1'b0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      cnt_d       = '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) wr_ptr_d[i] = wr_ptr_q[i] + AW'(1);
        if (pop[i])  rd_ptr_d[i] = rd_ptr_q[i] + AW'(1);
        cnt_d[i] = cnt_q[i] + (AW+1)'(push[i]) - (AW+1)'(pop[i]);
      end
      if (|pop) begin
        data_d      = head;
        valid_out_d = 1'b1;
        active_d    = 1'b1;
        state_d     = (state_q == EXP0) ? EXP1 : EXP0;
      end else if (valid_out_q && ready_out) begin
        valid_out_d = 1'b0;
        data_d      = '0;
      end
      if (drop) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= EXP0;
      data_q      <= '0;
      valid_out_q <= 1'b0;
      active_q    <= 1'b0;
      ovf_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      valid_out_q <= valid_out_d;
      active_q    <= active_d;
      ovf_q       <= ovf_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
    end
  end

  // Storage carries no reset; occupancy and pointers alone define what is valid.
  always_ff @(posedge clk_2f) begin
    for (int i = 0; i < 2; i++) begin
      if (wr_en[i]) mem[i][wr_ptr_q[i]] <= din[i];
    end
  end

  assign data_out     = data_q;
  assign valid_out    = valid_out_q;
  assign exp_lane     = state_q;
  assign active       = active_q;
  assign overflow_err = ovf_q;
  assign fill_0       = cnt_q[0];
  assign fill_1       = cnt_q[1];

endmodule

// File: tb/tb_unstrip_scheduler.sv
// Bench for unstrip_scheduler: directed scenarios followed by random traffic,
// all checked against a queue-based reference of the reassembly rules.
module tb_unstrip_scheduler;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int FW     = $clog2(DEPTH) + 1;

  logic              clk_2f = 1'b0;
  logic              reset_L = 1'b0;
  logic              flush = 1'b0;
  logic              valid_0 = 1'b0;
  logic              valid_1 = 1'b0;
  logic              ready_out = 1'b1;
  logic [DATA_W-1:0] lane_0 = '0;
  logic [DATA_W-1:0] lane_1 = '0;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              exp_lane;
  logic              active;
  logic              overflow_err;
  logic [FW-1:0]     fill_0;
  logic [FW-1:0]     fill_1;

  unstrip_scheduler #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk_2f(clk_2f), .reset_L(reset_L), .flush(flush),
    .valid_0(valid_0), .lane_0(lane_0), .valid_1(valid_1), .lane_1(lane_1),
    .ready_out(ready_out), .data_out(data_out), .valid_out(valid_out),
    .exp_lane(exp_lane), .active(active), .overflow_err(overflow_err),
    .fill_0(fill_0), .fill_1(fill_1)
  );

  always #5 clk_2f = ~clk_2f;

  int checks = 0;
  int failures = 0;

  // Reference state: two word queues, the lane owed next, and the output register.
  logic [DATA_W-1:0] q0[$];
  logic [DATA_W-1:0] q1[$];
  logic              m_exp, m_vout, m_active, m_ovf;
  logic [DATA_W-1:0] m_dout;

  task automatic model_clear();
    q0.delete();
    q1.delete();
    m_exp = 1'b0; m_vout = 1'b0; m_active = 1'b0; m_ovf = 1'b0; m_dout = '0;
  endtask

  task automatic model_step();
    bit slot, pop, acc0, acc1;
    if (!reset_L || flush) begin
      model_clear();
    end else begin
      slot = !m_vout || ready_out;
      pop  = slot && (m_exp ? (q1.size() > 0) : (q0.size() > 0));
      acc0 = valid_0 && ((q0.size() < DEPTH) || (pop && !m_exp));
      acc1 = valid_1 && ((q1.size() < DEPTH) || (pop && m_exp));
      if ((valid_0 && !acc0) || (valid_1 && !acc1)) m_ovf = 1'b1;
      if (pop) begin
        m_dout   = m_exp ? q1.pop_front() : q0.pop_front();
        m_vout   = 1'b1;
        m_active = 1'b1;
        m_exp    = !m_exp;
      end else if (m_vout && ready_out) begin
        m_vout = 1'b0;
        m_dout = '0;
      end
      if (acc0) q0.push_back(lane_0);
      if (acc1) q1.push_back(lane_1);
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".data_out"},     64'(data_out),     64'(m_dout));
    check({tag, ".valid_out"},    64'(valid_out),    64'(m_vout));
    check({tag, ".exp_lane"},     64'(exp_lane),     64'(m_exp));
    check({tag, ".active"},       64'(active),       64'(m_active));
    check({tag, ".overflow_err"}, 64'(overflow_err), 64'(m_ovf));
    check({tag, ".fill_0"},       64'(fill_0),       64'(q0.size()));
    check({tag, ".fill_1"},       64'(fill_1),       64'(q1.size()));
  endtask

  task automatic tick(input string tag);
    @(posedge clk_2f);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic v0, input logic [DATA_W-1:0] d0,
                       input logic v1, input logic [DATA_W-1:0] d1,
                       input logic rdy, input logic fl);
    valid_0 = v0; lane_0 = d0; valid_1 = v1; lane_1 = d1; ready_out = rdy; flush = fl;
  endtask

  initial begin
    model_clear();

    // Reset held with lanes toggling
    for (int i = 0; i < 3; i++) begin
      drive(1'(i), DATA_W'(i + 5), 1'(i + 1), DATA_W'(i + 9), 1'b1, 1'b0);
      tick("reset");
      check("reset.valid_out_zero", 64'(valid_out), 64'd0);
      check("reset.fill_0_zero", 64'(fill_0), 64'd0);
    end
    reset_L = 1'b1;
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    tick("idle");
    tick("idle");
    check("idle.valid_out", 64'(valid_out), 64'd0);

    // In-order reassembly
    drive(1'b1, 32'hA0, 1'b0, '0, 1'b1, 1'b0); tick("order1");
    drive(1'b0, '0, 1'b1, 32'hB0, 1'b1, 1'b0); tick("order2");
    check("order.first_word", 64'(data_out), 64'hA0);
    check("order.first_valid", 64'(valid_out), 64'd1);
    drive(1'b1, 32'hA1, 1'b0, '0, 1'b1, 1'b0); tick("order3");
    check("order.second_word", 64'(data_out), 64'hB0);
    drive(1'b0, '0, 1'b1, 32'hB1, 1'b1, 1'b0); tick("order4");
    check("order.third_word", 64'(data_out), 64'hA1);
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0); tick("order5");
    check("order.fourth_word", 64'(data_out), 64'hB1);
    tick("order6");
    check("order.drained", 64'(valid_out), 64'd0);

    // Skew: lane 1 arrives first
    drive(1'b0, '0, 1'b1, 32'h11, 1'b1, 1'b0); tick("skew1");
    check("skew.fill_1", 64'(fill_1), 64'd1);
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0); tick("skew2");
    check("skew.exp_lane_held", 64'(exp_lane), 64'd0);
    drive(1'b1, 32'h01, 1'b0, '0, 1'b1, 1'b0); tick("skew3");
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0); tick("skew4");
    check("skew.first_out", 64'(data_out), 64'h01);
    tick("skew5");
    check("skew.second_out", 64'(data_out), 64'h11);
    tick("skew6");

    // Back-pressure and overflow on lane 0
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b1); tick("bp_flush");
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, DATA_W'(32'h50 + i), 1'b0, '0, 1'b0, 1'b0);
      tick("bp");
      if (i == 4) check("bp.no_ovf_yet", 64'(overflow_err), 64'd0);
    end
    check("bp.held_word", 64'(data_out), 64'h50);
    check("bp.valid_held", 64'(valid_out), 64'd1);
    check("bp.fill_0_sat", 64'(fill_0), 64'd4);
    check("bp.overflow", 64'(overflow_err), 64'd1);

    // Flush mid-stream with fill_0=2 and a word held
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1); tick("fl_pre");
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, DATA_W'(32'h60 + i), 1'b0, '0, 1'b0, 1'b0);
      tick("fl_fill");
    end
    check("fl.fill_0_two", 64'(fill_0), 64'd2);
    drive(1'b1, 32'hEE, 1'b1, 32'hEF, 1'b0, 1'b1); tick("flush");
    check("flush.valid_out", 64'(valid_out), 64'd0);
    check("flush.fill_0", 64'(fill_0), 64'd0);
    check("flush.fill_1", 64'(fill_1), 64'd0);
    check("flush.active", 64'(active), 64'd0);
    drive(1'b1, 32'h77, 1'b0, '0, 1'b1, 1'b0); tick("post_flush1");
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0); tick("post_flush2");
    check("post_flush.first", 64'(data_out), 64'h77);

    // Asynchronous reset while a word is held
    drive(1'b1, 32'h88, 1'b0, '0, 1'b0, 1'b0); tick("ar1");
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0); tick("ar2");
    check("ar.valid_before", 64'(valid_out), 64'd1);
    #2;
    reset_L = 1'b0;
    #1;
    model_clear();
    check("ar.valid_async", 64'(valid_out), 64'd0);
    check("ar.data_async", 64'(data_out), 64'd0);
    check_all("ar_async");
    @(negedge clk_2f);
    reset_L = 1'b1;
    tick("ar_release");

    // Random traffic with occasional flush
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 1)), DATA_W'($urandom),
            1'($urandom_range(0, 1)), DATA_W'($urandom),
            (i < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 63) == 0));
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/unstrip_scheduler.md
# unstrip_scheduler

Two-lane reassembly scheduler for the byte-unstriping path, running entirely in the clk_2f domain. Each lane's words are captured into its own small FIFO, so inter-lane skew of a few cycles is absorbed. The original word order (lane 0, lane 1, lane 0, …) is rebuilt onto one registered output stream with a valid/ready handshake. Lane overflow is flagged sticky, and a synchronous flush re-aligns the scheduler.

## Interface
- DATA_W, 32, word width of each lane and of the output
- DEPTH, 4, entries per lane FIFO (power of two, ≥2)
- clk_2f  input  1  single clock; all logic on rising edge
- reset_L  input  1  asynchronous, active-low reset
- flush  input  1  synchronous clear of FIFOs, state, and output register
- valid_0  input  1  lane_0 word present this cycle
- lane_0  input  DATA_W  lane 0 word
- valid_1  input  1  lane_1 word present this cycle
- lane_1  input  DATA_W  lane 1 word
- ready_out  input  1  downstream accepts data_out this cycle
- data_out  output  DATA_W  reassembled word; 0 whenever valid_out=0
- valid_out  output  1  data_out holds a word
- exp_lane  output  1  lane the scheduler will pop next (0/1)
- active  output  1  at least one word popped since reset/flush
- overflow_err  output  1  sticky: a lane word was dropped
- fill_0, fill_1  output  log2(DEPTH)+1  current occupancy of each lane FIFO

## Operation
- Push: on every edge with valid_x=1, lane_x is written to FIFO x.
  - If FIFO x is full and is not being popped on the same edge, the word is dropped and overflow_err is set.
  - A push to a full FIFO on the same edge as its pop succeeds.
- Output slot is free when valid_out=0, or when valid_out=1 and ready_out=1.
- State machine has two states, EXP0 and EXP1; exp_lane mirrors the state.
  - EXP0: if FIFO 0 is non-empty and the output slot is free, pop FIFO 0 into the output register and go to EXP1. Otherwise hold.
  - EXP1: the same rule with FIFO 1; on a pop, go to EXP0.
  - The scheduler never pops the non-expected lane, even if only that lane has data. Order is strict.
- Output register:
  - On a pop: data_out ← FIFO head, valid_out ← 1.
  - Else if valid_out=1 and ready_out=1: valid_out ← 0, data_out ← 0.
  - Else: hold.
- active is set on the first pop and cleared only by reset or flush.
- overflow_err is cleared only by reset or flush.
- flush=1 at an edge has these effects:
  - Both FIFOs are emptied, and pushes in that same cycle are discarded.
  - State goes to EXP0.
  - valid_out ← 0, data_out ← 0, active ← 0, overflow_err ← 0.
  - flush has priority over all other activity.
- Widths: FIFO pointers are log2(DEPTH) bits with natural wrap. Occupancy is log2(DEPTH)+1 bits, range 0..DEPTH.

## Timing
- Reset (reset_L=0, asynchronous):
  - data_out=0, valid_out=0, exp_lane=0, active=0, overflow_err=0, fill_0=fill_1=0.
  - State is EXP0 and FIFO pointers are 0.
  - Deassertion takes effect at the next clk_2f edge.
- Latency: a word sampled at edge k into an empty, expected FIFO with a free output slot appears on data_out/valid_out after edge k+1.
- Throughput: one word per cycle when both lanes are fed alternately with ≥1 cycle of overlap and ready_out=1. This gives the full 2×f aggregate rate of the two lanes at f.
- Back-pressure:
  - With valid_out=1 and ready_out=0, data_out and valid_out hold and no pop occurs.
  - Lane FIFOs keep filling up to DEPTH; further words are dropped and overflow_err is set.
- Simultaneous push and pop on the same FIFO: occupancy is unchanged, and the popped word is the old head.
- Reset asserted mid-transfer: all state is lost immediately; no partial word is emitted.

## Test plan
- Reset: hold reset_L=0 for 3 edges with lanes toggling → all outputs 0, exp_lane=0, fill_0=fill_1=0. After release, an idle bus keeps valid_out=0.
- In-order reassembly: lane_0 = 0xA0, 0xA1 on edges 1 and 3; lane_1 = 0xB0, 0xB1 on edges 2 and 4; ready_out=1 → data_out sequence is A0, B0, A1, B1, with the first word valid after edge 2.
- Skew absorption: lane_1 words arrive 2 cycles before lane_0 words (0x11 then 0x01) → output is 0x01 then 0x11. fill_1 reaches 1 while waiting, and exp_lane stays 0 until the first pop.
- Back-pressure and overflow: ready_out=0 with valid_0=1 for 6 edges (DEPTH=4) → valid_out stays 1 with the first word, fill_0 saturates at 4, and overflow_err=1 after the 6th push. The held word is unchanged.
- Flush mid-stream: flush=1 for one edge while fill_0=2 and valid_out=1 → next cycle valid_out=0, fill_0=0, exp_lane=0, active=0, overflow_err=0. The next lane_0 word is emitted first.
- Async reset mid-operation: drop reset_L between edges while valid_out=1 → valid_out and data_out go to 0 immediately, without waiting for a clock edge.
